inta_sequencer: RTL

- Interrupt-acknowledge sequencer sitting directly upstream of the cascade block.
- Raises INT while a resolved request is pending and detects the two INTA# falling edges.
- Produces the pulse1/pulse2 strobes and the frozen interrupt ID that the cascade block consumes.
- Sets the in-service bit, and drives the 8-bit vector onto the data bus when the cascade block asserts vec_flag. Optionally performs automatic EOI.

---
 rtl/pic_pkg.sv | 19 +
 rtl/pin_sync.sv | 25 ++
 rtl/inta_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC blocks: acknowledge-sequencer states, the
// default spurious ID and a 3-to-8 one-hot decoder.
package pic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAck1,
    StWait2,
    StAck2,
    StVec
  } inta_state_e;

  localparam logic [2:0] SpuriousIdDefault = 3'd7;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// N-flop synchroniser for an asynchronous input pin, with an asynchronous
// active-low reset to a configurable idle level.
module pin_sync #(
  parameter int unsigned N        = 2,
  parameter logic        ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {N{ResetVal}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: raises INT, tracks the two INTA# pulses,
// latches the interrupt ID, strobes the in-service bit and drives the vector.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [2:0]  SPURIOUS_ID = SpuriousIdDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic       req_valid,
  input  logic [2:0] req_id,
  input  logic       vec_flag,
  input  logic [4:0] icw2_base,
  input  logic       aeoi,
  output logic       int_out,
  output logic       pulse1,
  output logic       pulse2,
  output logic [2:0] intr_id,
  output logic [7:0] isr_set,
  output logic [7:0] eoi_clr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  logic cur_s;
  logic prev_q;
  logic fall;
  logic rise;

  pin_sync #(
    .N        (SYNC_STAGES),
    .ResetVal (1'b1)
  ) u_inta_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (inta_n),
    .q_o   (cur_s)
  );

  assign fall = prev_q & ~cur_s;
  assign rise = ~prev_q & cur_s;

  inta_state_e state_q;
  logic        int_out_q;
  logic        pulse1_q;
  logic        pulse2_q;
  logic [2:0]  intr_id_q;
  logic        spurious_q;
  logic [7:0]  isr_set_q;
  logic [7:0]  eoi_clr_q;
  logic [7:0]  data_out_q;
  logic        data_oe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      prev_q     <= 1'b1;
      int_out_q  <= 1'b0;
      pulse1_q   <= 1'b0;
      pulse2_q   <= 1'b0;
      intr_id_q  <= 3'd0;
      spurious_q <= 1'b0;
      isr_set_q  <= 8'h00;
      eoi_clr_q  <= 8'h00;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
    end else begin
      prev_q    <= cur_s;
      pulse1_q  <= 1'b0;
      pulse2_q  <= 1'b0;
      isr_set_q <= 8'h00;
      eoi_clr_q <= 8'h00;
      unique case (state_q)
        StIdle: begin
          int_out_q <= req_valid;
          // A fall with no pending request is still acknowledged, as spurious.
          if (fall) begin
            state_q    <= StAck1;
            pulse1_q   <= 1'b1;
            int_out_q  <= 1'b0;
            intr_id_q  <= req_valid ? req_id : SPURIOUS_ID;
            spurious_q <= ~req_valid;
          end
        end
        StAck1: begin
          // In-service strobe trails pulse1 by a cycle so the strobes never overlap.
          isr_set_q <= spurious_q ? 8'h00 : onehot8(intr_id_q);
          state_q   <= StWait2;
        end
        StWait2: begin
          if (fall) begin
            state_q  <= StAck2;
            pulse2_q <= 1'b1;
          end
        end
        StAck2: begin
          data_oe_q  <= vec_flag;
          data_out_q <= vec_flag ? {icw2_base, intr_id_q} : 8'h00;
          state_q    <= StVec;
        end
        StVec: begin
          if (rise) begin
            eoi_clr_q  <= (aeoi && !spurious_q) ? onehot8(intr_id_q) : 8'h00;
            data_oe_q  <= 1'b0;
            data_out_q <= 8'h00;
            state_q    <= StIdle;
          end else begin
            data_oe_q  <= vec_flag;
            data_out_q <= vec_flag ? {icw2_base, intr_id_q} : 8'h00;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign int_out  = int_out_q;
  assign pulse1   = pulse1_q;
  assign pulse2   = pulse2_q;
  assign intr_id  = intr_id_q;
  assign isr_set  = isr_set_q;
  assign eoi_clr  = eoi_clr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule
